// File: rtl/demux_nch_reg_if.sv
// Bundles the producer and consumer sides of the registered 1-to-NUM_CH demultiplexer.
// The slave modport is the demux view; the master modport is the traffic source/sink view.
interface demux_nch_reg_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic [DATA_W-1:0]        in_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic                     sel_err;

    modport master (
        output in_valid, in_sel, in_bcast, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel_err
    );

    modport slave (
        input  in_valid, in_sel, in_bcast, in_data, out_ready,
        output in_ready, out_valid, out_data, sel_err
    );
endinterface

// File: rtl/demux_nch_reg.sv
// Registered 1-to-NUM_CH demultiplexer with valid/ready flow control and optional broadcast.
// Each channel owns a one-entry holding register so a stalled consumer only blocks its own lane.
module demux_nch_reg #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input logic            clk,
    input logic            rst,
    demux_nch_reg_if.slave bus
);
    // One extra bit so NUM_CH == 2**SEL_W still compares correctly
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] can_take;
    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] load;
    logic              sel_legal;
    logic              ready_int;
    logic              accept;
    logic              sel_err_reg;

    assign sel_legal = ({1'b0, bus.in_sel} < NUM_CH_W);

    // Illegal selects are always accepted so a bad beat can never wedge the producer
    always_comb begin
        ready_int = 1'b1;
        if (bus.in_bcast) begin
            ready_int = &can_take;
        end else if (sel_legal) begin
            ready_int = |(sel_hit & can_take);
        end
    end

    assign accept       = bus.in_valid && ready_int;
    assign bus.in_ready = ready_int;
    assign bus.sel_err  = sel_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_reg <= 1'b0;
        end else begin
            sel_err_reg <= accept && !bus.in_bcast && !sel_legal;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic              full_reg;
        logic [DATA_W-1:0] data_reg;

        assign can_take[gi] = !full_reg || bus.out_ready[gi];
        assign sel_hit[gi]  = (bus.in_sel == SEL_W'(gi));
        assign load[gi]     = accept && (bus.in_bcast || sel_hit[gi]);

        // Load wins over drain so back-to-back beats stream at full rate
        always_ff @(posedge clk) begin
            if (rst) begin
                full_reg <= 1'b0;
                data_reg <= '0;
            end else if (load[gi]) begin
                full_reg <= 1'b1;
                data_reg <= bus.in_data;
            end else if (bus.out_ready[gi]) begin
                full_reg <= 1'b0;
            end
        end

        assign bus.out_valid[gi]                   = full_reg;
        assign bus.out_data[gi*DATA_W +: DATA_W]   = data_reg;
    end
endmodule

// File: tb/tb_demux_nch_reg.sv
// Directed bench for demux_nch_reg: per-channel scoreboard queues fed on accept, drained on
// output handshake, plus directed checks of ready, valid, hold and select-error behaviour.
module tb_demux_nch_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] sb_q [4][$];

    demux_nch_reg_if #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) bus ();
    demux_nch_reg_if #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) bus3 ();

    demux_nch_reg #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    demux_nch_reg #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after posedge, so the negedge view equals the next edge's view
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) sb_q[c].delete();
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (bus.out_valid[c] && bus.out_ready[c]) begin
                    if (sb_q[c].size() == 0) begin
                        chk($sformatf("sb_underflow_ch%0d", c), 32'(bus.out_data[c*8 +: 8]), 32'hxxxx_xxxx);
                    end else begin
                        chk($sformatf("sb_data_ch%0d", c), 32'(bus.out_data[c*8 +: 8]), 32'(sb_q[c].pop_front()));
                    end
                    $display("tb: ch%0d delivered %02h", c, bus.out_data[c*8 +: 8]);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int c = 0; c < 4; c++) begin
                    if (bus.in_bcast || (int'(bus.in_sel) == c)) sb_q[c].push_back(bus.in_data);
                end
                $display("tb: accept sel=%0d bcast=%0b data=%02h", bus.in_sel, bus.in_bcast, bus.in_data);
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_bcast  = 1'b0;
        bus.in_data   = 8'hFF;
        bus.out_ready = 4'h0;
        bus3.in_valid  = 1'b0;
        bus3.in_sel    = 2'd0;
        bus3.in_bcast  = 1'b0;
        bus3.in_data   = 8'h00;
        bus3.out_ready = 3'b000;

        // 1. Reset held two cycles with a beat offered
        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_sel_err", 32'(bus.sel_err), 32'h0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("rst_no_load", 32'(bus.out_valid), 32'h0);

        // 2. Routing to each channel with consumers always ready
        bus.out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(k);
            bus.in_data  = 8'hA0 + 8'(k);
            #1;
            chk($sformatf("route_ready_%0d", k), 32'(bus.in_ready), 32'h1);
            step();
            chk($sformatf("route_valid_%0d", k), 32'(bus.out_valid), 32'(1 << k));
            chk($sformatf("route_data_%0d", k), 32'(bus.out_data[k*8 +: 8]), 32'hA0 + 32'(k));
        end
        bus.in_valid = 1'b0;
        step();
        chk("route_drained", 32'(bus.out_valid), 32'h0);
        chk("route_no_sel_err", 32'(bus.sel_err), 32'h0);

        // 3. Backpressure on ch2 must not block ch0
        bus.out_ready = 4'b1011;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd2;
        bus.in_data   = 8'h11;
        step();
        chk("bp_ch2_full", 32'(bus.out_valid[2]), 32'h1);
        bus.in_data = 8'h22;
        #1;
        chk("bp_ch2_blocked", 32'(bus.in_ready), 32'h0);
        step();
        chk("bp_ch2_hold", 32'(bus.out_data[23:16]), 32'h11);
        bus.in_sel  = 2'd0;
        bus.in_data = 8'h55;
        #1;
        chk("bp_ch0_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk("bp_ch0_valid", 32'(bus.out_valid[0]), 32'h1);
        chk("bp_ch2_still_hold", 32'(bus.out_data[23:16]), 32'h11);
        bus.in_sel  = 2'd2;
        bus.in_data = 8'h22;
        #1;
        chk("bp_ch2_blocked2", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 4'hF;
        #1;
        chk("bp_ch2_release", 32'(bus.in_ready), 32'h1);
        step();
        chk("bp_ch2_new", 32'(bus.out_data[23:16]), 32'h22);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drained", 32'(bus.out_valid), 32'h0);

        // 4. Drain and load on the same channel in the same cycle
        bus.out_ready = 4'b1101;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd1;
        bus.in_data   = 8'h33;
        step();
        chk("dl_first", 32'(bus.out_data[15:8]), 32'h33);
        bus.out_ready = 4'hF;
        bus.in_data   = 8'h44;
        #1;
        chk("dl_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk("dl_valid", 32'(bus.out_valid[1]), 32'h1);
        chk("dl_data", 32'(bus.out_data[15:8]), 32'h44);
        bus.in_valid = 1'b0;
        step();

        // 5. Broadcast is atomic against a stalled channel
        bus.out_ready = 4'b0111;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd3;
        bus.in_data   = 8'h66;
        step();
        bus.in_bcast = 1'b1;
        bus.in_sel   = 2'd0;
        bus.in_data  = 8'h5A;
        #1;
        chk("bc_blocked", 32'(bus.in_ready), 32'h0);
        step();
        chk("bc_no_load", 32'(bus.out_valid), 32'h8);
        chk("bc_ch3_hold", 32'(bus.out_data[31:24]), 32'h66);
        bus.out_ready = 4'hF;
        #1;
        chk("bc_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk("bc_all_valid", 32'(bus.out_valid), 32'hF);
        chk("bc_all_data", bus.out_data, 32'h5A5A_5A5A);
        bus.in_valid = 1'b0;
        bus.in_bcast = 1'b0;
        step();
        chk("bc_drained", 32'(bus.out_valid), 32'h0);

        // 6. Illegal select on the three-channel instance
        bus3.out_ready = 3'b111;
        bus3.in_valid  = 1'b1;
        bus3.in_sel    = 2'd3;
        bus3.in_data   = 8'h77;
        #1;
        chk("ill_ready", 32'(bus3.in_ready), 32'h1);
        step();
        $display("tb: ch3-instance accepted illegal sel=3 data=77");
        bus3.in_valid = 1'b0;
        chk("ill_sel_err", 32'(bus3.sel_err), 32'h1);
        chk("ill_no_valid", 32'(bus3.out_valid), 32'h0);
        step();
        chk("ill_sel_err_pulse", 32'(bus3.sel_err), 32'h0);
        chk("ill_no_valid2", 32'(bus3.out_valid), 32'h0);

        // 7. Reset while channels are full and stalled
        bus.out_ready = 4'h0;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'd0;
        bus.in_data   = 8'h81;
        step();
        bus.in_sel  = 2'd1;
        bus.in_data = 8'h82;
        step();
        chk("mid_full", 32'(bus.out_valid), 32'h3);
        bus.in_sel  = 2'd2;
        bus.in_data = 8'h83;
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_data", bus.out_data, 32'h0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("mid_after_rst", 32'(bus.out_valid), 32'h0);

        for (int c = 0; c < 4; c++) begin
            chk($sformatf("sb_empty_ch%0d", c), 32'(sb_q[c].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
